// File: rtl/smc_arb_lite.sv
// ---------------------------------------------------------------------------
// smc_arb_lite
//
// Round-robin request arbiter sharing the lite Static Memory Controller
// between four internal requesters (AHB slave, DMA, two spare ports).
// The winner's read strobe and chip select are registered and presented
// to the SMC together with new_access. The grant is held until the SMC
// reports the last cycle of the access (smc_done together with mac_done).
// A requester may lock the SMC for back-to-back accesses. The lock is
// bounded by MAX_LOCK consecutive accesses, after which the arbiter rotates.
//
// Parameters
//   MAX_LOCK    max consecutive accesses per locked requester (2..15)
//
// Ports
//   sys_clk     system clock, all state on rising edge
//   n_sys_reset asynchronous active-low reset
//   req         per-requester access request, held until its ack
//   req_lock    per-requester lock request, sampled at completion
//   req_n_read  per-requester active-low read
//   req_cs      per-requester chip select
//   smc_done    SMC: current access is in its last cycle
//   mac_done    SMC MAC: all sub-cycles of a multiple access are done
//   gnt         one-hot registered grant
//   gnt_id      encoded index of the granted requester (0 when none)
//   ack         one-cycle completion pulse to the owner
//   new_access  valid access to the SMC
//   n_read      registered read strobe of the owner
//   cs          registered chip select of the owner
//   arb_busy    a grant is outstanding
// ---------------------------------------------------------------------------
module smc_arb_lite #(
    parameter int unsigned MAX_LOCK = 8
) (
    input  logic       sys_clk,
    input  logic       n_sys_reset,
    input  logic [3:0] req,
    input  logic [3:0] req_lock,
    input  logic [3:0] req_n_read,
    input  logic [3:0] req_cs,
    input  logic       smc_done,
    input  logic       mac_done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic [3:0] ack,
    output logic       new_access,
    output logic       n_read,
    output logic       cs,
    output logic       arb_busy
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    // lock_cnt counts re-grants within one locked run; the run may hold
    // MAX_LOCK accesses in total, so the last one sees MAX_LOCK-1.
    localparam logic [3:0] LOCK_LAST = 4'(MAX_LOCK - 1);

    logic [0:0] state_q, state_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] rr_ptr_q, rr_ptr_d;
    logic [3:0] lock_cnt_q, lock_cnt_d;
    logic       n_read_q, n_read_d;
    logic       cs_q, cs_d;

    logic       busy;
    logic       done_evt;
    logic [3:0] owner_relock;
    logic       keep_owner;
    logic [3:0] cand;
    logic [3:0] win_oh;
    logic [1:0] win_idx;
    logic [1:0] own_idx;

    // First set bit of cand in order ptr+1 .. ptr+4. Since ptr is the last
    // winner, a re-requesting owner is naturally considered last.
    function automatic logic [3:0] rr_pick(input logic [3:0] c, input logic [1:0] ptr);
        logic [3:0] oh;
        logic [1:0] idx;
        logic       found;
        oh    = '0;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && c[idx]) begin
                oh[idx] = 1'b1;
                found   = 1'b1;
            end
        end
        return oh;
    endfunction

    function automatic logic [1:0] enc(input logic [3:0] oh);
        logic [1:0] idx;
        unique case (oh)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // ------------------------------------------------------------------
    // Completion and candidate selection
    // ------------------------------------------------------------------
    always_comb begin
        busy         = (state_q == ST_BUSY);
        // smc_done alone only ends one sub-cycle of a multiple access
        done_evt     = busy & smc_done & mac_done;
        owner_relock = gnt_q & req & req_lock;
        keep_owner   = (|owner_relock) && (lock_cnt_q < LOCK_LAST);
        // In BUSY the owner competes again only when it asks to stay locked;
        // a plain req still high from the owner is ignored at completion.
        if (busy) begin
            cand = (req & ~gnt_q) | owner_relock;
        end else begin
            cand = req;
        end
        win_oh  = rr_pick(cand, rr_ptr_q);
        win_idx = enc(win_oh);
        own_idx = enc(gnt_q);
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        rr_ptr_d   = rr_ptr_q;
        lock_cnt_d = lock_cnt_q;
        n_read_d   = n_read_q;
        cs_d       = cs_q;

        unique case (state_q)
            ST_IDLE: begin
                if (|cand) begin
                    state_d    = ST_BUSY;
                    gnt_d      = win_oh;
                    rr_ptr_d   = win_idx;
                    lock_cnt_d = 4'd0;
                    n_read_d   = req_n_read[win_idx];
                    cs_d       = req_cs[win_idx];
                end
            end
            ST_BUSY: begin
                // Without done_evt everything stays frozen, including the
                // owner's attributes even if its inputs change.
                if (done_evt) begin
                    if (keep_owner) begin
                        lock_cnt_d = lock_cnt_q + 4'd1;
                        n_read_d   = req_n_read[own_idx];
                        cs_d       = req_cs[own_idx];
                    end else if (|cand) begin
                        // Straight handover keeps new_access high with no
                        // idle cycle, so the SMC can hold chip select.
                        gnt_d      = win_oh;
                        rr_ptr_d   = win_idx;
                        lock_cnt_d = 4'd0;
                        n_read_d   = req_n_read[win_idx];
                        cs_d       = req_cs[win_idx];
                    end else begin
                        state_d    = ST_IDLE;
                        gnt_d      = 4'b0000;
                        lock_cnt_d = 4'd0;
                        n_read_d   = 1'b1;
                        cs_d       = 1'b0;
                    end
                end
            end
            default: begin
                state_d    = ST_IDLE;
                gnt_d      = 4'b0000;
                lock_cnt_d = 4'd0;
                n_read_d   = 1'b1;
                cs_d       = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge n_sys_reset) begin
        if (!n_sys_reset) begin
            state_q    <= ST_IDLE;
            gnt_q      <= 4'b0000;
            rr_ptr_q   <= 2'd3;  // requester 0 wins the first arbitration
            lock_cnt_q <= 4'd0;
            n_read_q   <= 1'b1;
            cs_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_cnt_q <= lock_cnt_d;
            n_read_q   <= n_read_d;
            cs_q       <= cs_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        gnt        = gnt_q;
        gnt_id     = own_idx;
        ack        = gnt_q & {4{done_evt}};
        arb_busy   = busy;
        new_access = busy;
        n_read     = n_read_q;
        cs         = cs_q;
    end

endmodule
